// File: rtl/clock_time_keeper.sv
`default_nettype none
// ============================================================================
// Module   : clock_time_keeper
// Brief    : 1 Hz prescaler and 24-hour BCD timekeeper with manual set inputs.
// Revision : 1.0 - initial release
// ============================================================================
module clock_time_keeper #(
   parameter int CLK_HZ = 50000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       run,
   input  logic       set_en,
   input  logic       inc_min,
   input  logic       inc_hour,
   output logic [5:0] sec_ones,
   output logic [5:0] sec_tens,
   output logic [5:0] min_ones,
   output logic [5:0] min_tens,
   output logic [5:0] hour_ones,
   output logic [5:0] hour_tens,
   output logic       tick_1hz,
   output logic       day_wrap
);

   localparam int               PRE_W   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_HZ - 1);

   logic [PRE_W-1:0] r_pre;
   logic [3:0]       r_sec_ones, r_sec_tens, r_min_ones, r_min_tens, r_hour_ones, r_hour_tens;
   logic             r_inc_min_q, r_inc_hour_q;
   logic             r_tick, r_day_wrap;

   logic       w_sec_adv, w_min_edge, w_hour_edge;
   logic       w_min_step, w_hour_step, w_day_wrap;
   logic [3:0] w_sec_ones_nxt, w_sec_tens_nxt, w_min_ones_nxt, w_min_tens_nxt;
   logic [3:0] w_hour_ones_nxt, w_hour_tens_nxt;

   assign w_sec_adv   = run & ~set_en & (r_pre == PRE_MAX);
   assign w_min_edge  = inc_min  & ~r_inc_min_q;
   assign w_hour_edge = inc_hour & ~r_inc_hour_q;

   // Minute/hour steps are shared by the seconds carry and the set-mode buttons;
   // a set-mode minute step never carries into the hours.
   always_comb begin
      w_sec_ones_nxt  = r_sec_ones;
      w_sec_tens_nxt  = r_sec_tens;
      w_min_ones_nxt  = r_min_ones;
      w_min_tens_nxt  = r_min_tens;
      w_hour_ones_nxt = r_hour_ones;
      w_hour_tens_nxt = r_hour_tens;
      w_min_step      = 1'b0;
      w_hour_step     = 1'b0;
      w_day_wrap      = 1'b0;

      if (set_en) begin
         w_sec_ones_nxt = 4'd0;
         w_sec_tens_nxt = 4'd0;
         w_min_step     = w_min_edge;
         w_hour_step    = w_hour_edge;
      end else if (w_sec_adv) begin
         if (r_sec_ones == 4'd9) begin
            w_sec_ones_nxt = 4'd0;
            if (r_sec_tens == 4'd5) begin
               w_sec_tens_nxt = 4'd0;
               w_min_step     = 1'b1;
               w_hour_step    = (r_min_tens == 4'd5) && (r_min_ones == 4'd9);
            end else begin
               w_sec_tens_nxt = r_sec_tens + 4'd1;
            end
         end else begin
            w_sec_ones_nxt = r_sec_ones + 4'd1;
         end
         w_day_wrap = (r_hour_tens == 4'd2) && (r_hour_ones == 4'd3) &&
                      (r_min_tens  == 4'd5) && (r_min_ones  == 4'd9) &&
                      (r_sec_tens  == 4'd5) && (r_sec_ones  == 4'd9);
      end

      if (w_min_step) begin
         if (r_min_ones == 4'd9) begin
            w_min_ones_nxt = 4'd0;
            w_min_tens_nxt = (r_min_tens == 4'd5) ? 4'd0 : r_min_tens + 4'd1;
         end else begin
            w_min_ones_nxt = r_min_ones + 4'd1;
         end
      end

      if (w_hour_step) begin
         if ((r_hour_tens == 4'd2) && (r_hour_ones == 4'd3)) begin
            w_hour_ones_nxt = 4'd0;
            w_hour_tens_nxt = 4'd0;
         end else if (r_hour_ones == 4'd9) begin
            w_hour_ones_nxt = 4'd0;
            w_hour_tens_nxt = r_hour_tens + 4'd1;
         end else begin
            w_hour_ones_nxt = r_hour_ones + 4'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pre        <= '0;
         r_sec_ones   <= 4'd0;
         r_sec_tens   <= 4'd0;
         r_min_ones   <= 4'd0;
         r_min_tens   <= 4'd0;
         r_hour_ones  <= 4'd0;
         r_hour_tens  <= 4'd0;
         r_inc_min_q  <= 1'b1;
         r_inc_hour_q <= 1'b1;
         r_tick       <= 1'b0;
         r_day_wrap   <= 1'b0;
      end else begin
         if (set_en) begin
            r_pre <= '0;
         end else if (run) begin
            r_pre <= (r_pre == PRE_MAX) ? '0 : r_pre + 1'b1;
         end
         r_sec_ones   <= w_sec_ones_nxt;
         r_sec_tens   <= w_sec_tens_nxt;
         r_min_ones   <= w_min_ones_nxt;
         r_min_tens   <= w_min_tens_nxt;
         r_hour_ones  <= w_hour_ones_nxt;
         r_hour_tens  <= w_hour_tens_nxt;
         r_inc_min_q  <= inc_min;
         r_inc_hour_q <= inc_hour;
         r_tick       <= w_sec_adv;
         r_day_wrap   <= w_day_wrap;
      end
   end

   assign sec_ones  = {2'b00, r_sec_ones};
   assign sec_tens  = {2'b00, r_sec_tens};
   assign min_ones  = {2'b00, r_min_ones};
   assign min_tens  = {2'b00, r_min_tens};
   assign hour_ones = {2'b00, r_hour_ones};
   assign hour_tens = {2'b00, r_hour_tens};
   assign tick_1hz  = r_tick;
   assign day_wrap  = r_day_wrap;

endmodule
`default_nettype wire

// File: tb/tb_clock_time_keeper.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock_time_keeper
// Brief    : Scoreboard bench for clock_time_keeper with CLK_HZ = 4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clock_time_keeper;

   localparam int CLK_HZ = 4;

   logic       clk;
   logic       reset, run, set_en, inc_min, inc_hour;
   logic [5:0] sec_ones, sec_tens, min_ones, min_tens, hour_ones, hour_tens;
   logic       tick_1hz, day_wrap;

   clock_time_keeper #(.CLK_HZ(CLK_HZ)) dut (
      .clk       (clk),
      .reset     (reset),
      .run       (run),
      .set_en    (set_en),
      .inc_min   (inc_min),
      .inc_hour  (inc_hour),
      .sec_ones  (sec_ones),
      .sec_tens  (sec_tens),
      .min_ones  (min_ones),
      .min_tens  (min_tens),
      .hour_ones (hour_ones),
      .hour_tens (hour_tens),
      .tick_1hz  (tick_1hz),
      .day_wrap  (day_wrap)
   );

   typedef struct {
      int          cyc;
      logic [35:0] t;
      logic        wrap;
   } tick_t;

   typedef struct {
      logic [35:0] t;
      logic        tick;
   } probe_t;

   tick_t  tick_q[$];
   probe_t probe_q[$];

   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   bit          mon_en = 1'b0;
   bit          done = 1'b0;
   logic [35:0] w_act;

   assign w_act = {hour_tens, hour_ones, min_tens, min_ones, sec_tens, sec_ones};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [35:0] hms(input int hh, input int mm, input int ss);
      return {6'(hh / 10), 6'(hh % 10), 6'(mm / 10), 6'(mm % 10), 6'(ss / 10), 6'(ss % 10)};
   endfunction

   task automatic exp_tick(input int c, input int hh, input int mm, input int ss, input logic w);
      tick_t e;
      e.cyc  = c;
      e.t    = hms(hh, mm, ss);
      e.wrap = w;
      tick_q.push_back(e);
   endtask

   // Expected state after the next rising edge; consumes one cycle.
   task automatic probe(input int hh, input int mm, input int ss);
      probe_t p;
      p.t    = hms(hh, mm, ss);
      p.tick = 1'b0;
      probe_q.push_back(p);
      @(negedge clk);
   endtask

   task automatic pulse_min(input int n);
      repeat (n) begin
         inc_min = 1'b1;
         @(negedge clk);
         inc_min = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic pulse_hour(input int n);
      repeat (n) begin
         inc_hour = 1'b1;
         @(negedge clk);
         inc_hour = 1'b0;
         @(negedge clk);
      end
   endtask

   // Monitor: samples 1 time unit after each rising edge.
   always @(posedge clk) begin
      tick_t  e;
      probe_t p;
      #1;
      if (mon_en) begin
         checks++;
         if (sec_ones > 6'd9 || sec_tens > 6'd5 || min_ones > 6'd9 || min_tens > 6'd5 ||
             hour_ones > 6'd9 || hour_tens > 6'd2 || (hour_tens == 6'd2 && hour_ones > 6'd3)) begin
            errors++;
            $display("FAIL range@%0d: digits=%h are not a legal time", cyc, w_act);
         end

         while (tick_q.size() > 0 && tick_q[0].cyc < cyc) begin
            e = tick_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_tick: tick absent, required at cycle %0d time=%h", e.cyc, e.t);
         end

         if (tick_1hz === 1'b1) begin
            checks++;
            if (tick_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_tick@%0d: tick=1 time=%h, required no tick", cyc, w_act);
            end else begin
               e = tick_q.pop_front();
               if (e.cyc != cyc || w_act !== e.t || day_wrap !== e.wrap) begin
                  errors++;
                  $display("FAIL tick@%0d: got cyc=%0d time=%h wrap=%b, required cyc=%0d time=%h wrap=%b",
                           cyc, cyc, w_act, day_wrap, e.cyc, e.t, e.wrap);
               end
            end
         end else begin
            checks++;
            if (day_wrap !== 1'b0 || tick_1hz !== 1'b0) begin
               errors++;
               $display("FAIL idle@%0d: got tick=%b wrap=%b, required tick=0 wrap=0", cyc, tick_1hz, day_wrap);
            end
         end

         if (probe_q.size() > 0) begin
            p = probe_q.pop_front();
            checks++;
            if (w_act !== p.t || tick_1hz !== p.tick) begin
               errors++;
               $display("FAIL probe@%0d: got time=%h tick=%b, required time=%h tick=%b",
                        cyc, w_act, tick_1hz, p.t, p.tick);
            end
         end
      end

      if (done) begin
         while (tick_q.size() > 0) begin
            e = tick_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_tick_end: tick absent, required at cycle %0d", e.cyc);
         end
         $display("Simulation finished: %0d checks, %0d errors", checks, errors);
         $finish;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: stimulus did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int base;
      reset    = 1'b1;
      run      = 1'b0;
      set_en   = 1'b0;
      inc_min  = 1'b0;
      inc_hour = 1'b0;
      @(negedge clk);
      mon_en = 1'b1;
      probe(0, 0, 0);

      // Free run: ten ticks, 4 cycles apart
      reset = 1'b0;
      run   = 1'b1;
      base  = cyc;
      for (int k = 1; k <= 10; k++) exp_tick(base + 4 * k, 0, 0, k, 1'b0);
      repeat (40) @(negedge clk);
      run = 1'b0;

      // Freeze at pre=2 for 10 cycles; tick 2 cycles after resume
      run = 1'b1;
      repeat (2) @(negedge clk);
      run = 1'b0;
      repeat (10) @(negedge clk);
      run = 1'b1;
      exp_tick(cyc + 2, 0, 0, 11, 1'b0);
      repeat (2) @(negedge clk);
      run = 1'b0;

      // Set mode entered mid-second clears seconds and the prescaler
      run = 1'b1;
      @(negedge clk);
      set_en = 1'b1;
      probe(0, 0, 0);
      repeat (2) @(negedge clk);
      set_en = 1'b0;
      exp_tick(cyc + 4, 0, 0, 1, 1'b0);
      repeat (4) @(negedge clk);
      run = 1'b0;

      // Set-mode increments
      set_en = 1'b1;
      pulse_min(61);
      probe(0, 1, 0);
      inc_hour = 1'b1;
      repeat (20) @(negedge clk);
      inc_hour = 1'b0;
      @(negedge clk);
      probe(1, 1, 0);
      pulse_hour(23);
      probe(0, 1, 0);
      pulse_hour(24);
      probe(0, 1, 0);
      pulse_min(59);
      probe(0, 0, 0);
      inc_min  = 1'b1;
      inc_hour = 1'b1;
      @(negedge clk);
      inc_min  = 1'b0;
      inc_hour = 1'b0;
      probe(1, 1, 0);

      // Increments ignored outside set mode
      set_en = 1'b0;
      pulse_min(3);
      pulse_hour(3);
      probe(1, 1, 0);

      // Full carry chain from 23:59:00
      set_en = 1'b1;
      pulse_hour(22);
      pulse_min(58);
      probe(23, 59, 0);
      set_en = 1'b0;
      run    = 1'b1;
      base   = cyc;
      for (int k = 1; k <= 59; k++) exp_tick(base + 4 * k, 23, 59, k, 1'b0);
      exp_tick(base + 240, 0, 0, 0, 1'b1);
      for (int k = 1; k <= 3; k++) exp_tick(base + 240 + 4 * k, 0, 0, k, 1'b0);
      repeat (255) @(negedge clk);

      // Reset on the tick edge with inc_min rising
      reset   = 1'b1;
      inc_min = 1'b1;
      probe(0, 0, 0);
      reset  = 1'b0;
      run    = 1'b0;
      set_en = 1'b1;
      repeat (3) @(negedge clk);
      probe(0, 0, 0);
      inc_min = 1'b0;
      @(negedge clk);
      inc_min = 1'b1;
      @(negedge clk);
      inc_min = 1'b0;
      probe(0, 1, 0);

      repeat (2) @(negedge clk);
      done = 1'b1;
   end

endmodule
`default_nettype wire
